// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the Game Boy ALU over M-cycles and merges result/flag bytes
package gate_boy_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_XOR = 4'd5,
        ALU_OR  = 4'd6
    } alu_ops_t;
endpackage

module alu_sequencer
    import gate_boy_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_op,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    input  logic [FLAG_WIDTH-1:0]   flags_in,
    output alu_ops_t                alu_opcode,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic                    alu_cin,
    output logic                    alu_en,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [FLAG_WIDTH-1:0]   alu_flags,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic [FLAG_WIDTH-1:0]   res_flags
);
    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;
    localparam logic [3:0] OP_ADC = 4'd1, OP_SBC = 4'd3, OP_CP = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8, OP_DEC = 4'd9, OP_ADD16 = 4'd10;
    localparam logic [FLAG_WIDTH-1:0] FMASK = 8'hF0;

    state_t                  state_q;
    logic [1:0]              t_q;
    logic                    pend_q;
    logic [3:0]              op_q, op_d;
    logic [2*DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, data8;
    logic [FLAG_WIDTH-1:0]   f_q, f_d, flags8;
    logic [DATA_WIDTH-1:0]   lo_q, b8_d;
    logic                    acc, rsv, incdec, cin_d;
    alu_ops_t                opc_d;

    // Request latch muxing, per-op ALU drive and 8-bit result/flag merge
    always_comb begin
        acc    = req_valid && req_ready;
        op_d   = acc ? req_op : op_q;
        a_d    = acc ? req_a : a_q;
        b_d    = acc ? req_b : b_q;
        f_d    = acc ? flags_in : f_q;
        rsv    = op_q > OP_ADD16;
        incdec = op_q == OP_INC || op_q == OP_DEC;
        opc_d  = op_d <= 4'd6 ? alu_ops_t'(op_d) : (op_d == OP_CP || op_d == OP_DEC) ? ALU_SUB : ALU_ADD;
        b8_d   = (op_d == OP_INC || op_d == OP_DEC) ? 8'd1 : b_d[DATA_WIDTH-1:0];
        cin_d  = (op_d == OP_ADC || op_d == OP_SBC) && f_d[4];
        data8  = rsv ? '0 : {{DATA_WIDTH{1'b0}}, op_q == OP_CP ? a_q[DATA_WIDTH-1:0] : alu_result};
        flags8 = rsv ? f_q & FMASK : incdec ? {alu_flags[7:5], f_q[4], 4'h0} : alu_flags & FMASK;
    end

    // Sequencer FSM with free-running T-state counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            t_q        <= '0;
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= '0;
            lo_q       <= '0;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            alu_en     <= 1'b0;
            alu_cin    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= ALU_ADD;
            res_data   <= '0;
            res_flags  <= '0;
        end else begin
            t_q    <= t_q + 2'd1;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            f_q    <= f_d;
            pend_q <= pend_q || acc;
            alu_en <= (state_q == LO || state_q == HI) && t_q == 2'd0 && !rsv;
            done   <= 1'b0;
            if (acc)
                req_ready <= 1'b0;
            case (state_q)
                IDLE: if ((pend_q || acc) && t_q == 2'd3) begin
                    state_q    <= LO;
                    pend_q     <= 1'b0;
                    alu_opcode <= opc_d;
                    alu_a      <= a_d[DATA_WIDTH-1:0];
                    alu_b      <= b8_d;
                    alu_cin    <= cin_d;
                end
                LO: if (t_q == 2'd3) begin
                    lo_q <= alu_result;
                    if (op_q == OP_ADD16) begin
                        state_q    <= HI;
                        alu_opcode <= ALU_ADC;
                        alu_a      <= a_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        alu_b      <= b_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        alu_cin    <= alu_flags[4];
                    end else begin
                        state_q   <= FIN;
                        done      <= 1'b1;
                        res_data  <= data8;
                        res_flags <= flags8;
                    end
                end
                HI: if (t_q == 2'd3) begin
                    state_q   <= FIN;
                    done      <= 1'b1;
                    res_data  <= {alu_result, lo_q};
                    res_flags <= {f_q[7], 1'b0, alu_flags[5:4], 4'h0};
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench with an external ALU model and op-level reference
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [7:0]  flags_in;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin, alu_en;
    logic [7:0]  alu_result = 8'h00;
    logic [7:0]  alu_flags = 8'h00;
    logic        done;
    logic [15:0] res_data;
    logic [7:0]  res_flags;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  f;
        int          en;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         en_cnt = 0;
    logic [1:0] tb_t = 2'd0;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flags_in(flags_in),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_en(alu_en), .alu_result(alu_result), .alu_flags(alu_flags),
        .done(done), .res_data(res_data), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    // Game Boy ALU: registers {flags, result} on alu_en; low flag nibble carries junk on purpose
    function automatic logic [15:0] alu_model(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b, input logic ci);
        int x, y, c, r;
        logic z, n, h, cy;
        x = a; y = b; c = (opc == 1 || opc == 3) ? int'(ci) : 0;
        n = 0; h = 0; cy = 0;
        case (opc)
            0, 1: begin r = x + y + c; h = (x % 16 + y % 16 + c) > 15; cy = r > 255; end
            2, 3: begin r = x - y - c; h = (x % 16) < (y % 16 + c); cy = x < y + c; n = 1; end
            4: begin r = x & y; h = 1; end
            5: r = x ^ y;
            default: r = x | y;
        endcase
        z = r[7:0] == 8'h00;
        return {z, n, h, cy, a[3:0] | 4'h1, r[7:0]};
    endfunction

    always @(posedge clk) begin
        if (alu_en) {alu_flags, alu_result} <= alu_model(alu_opcode, alu_a, alu_b, alu_cin);
        tb_t <= !rst ? 2'd0 : tb_t + 2'd1;
        cyc  <= cyc + 1;
    end

    // Op-level reference: {res_data, res_flags} from the instruction semantics directly
    function automatic logic [23:0] ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
        int x, y, c, r;
        logic z, n, h, cy;
        logic [15:0] d;
        if (op > 10) return {16'h0000, f[7:4], 4'h0};
        if (op == 10) begin
            r = int'(a) + int'(b);
            h = (int'(a) % 4096 + int'(b) % 4096) > 4095;
            cy = r > 65535;
            d = r[15:0];
            return {d, f[7], 1'b0, h, cy, 4'h0};
        end
        x = a[7:0]; y = (op == 8 || op == 9) ? 1 : int'(b[7:0]);
        c = (op == 1 || op == 3) ? int'(f[4]) : 0;
        n = (op == 2 || op == 3 || op == 7 || op == 9);
        h = 0; cy = 0;
        if (op == 0 || op == 1 || op == 8) begin
            r = x + y + c; h = (x % 16 + y % 16 + c) > 15; cy = r > 255;
        end else if (n) begin
            r = x - y - c; h = (x % 16) < (y % 16 + c); cy = x < y + c;
        end else if (op == 4) begin
            r = x & y; h = 1;
        end else if (op == 5) r = x ^ y;
        else r = x | y;
        z = r[7:0] == 8'h00;
        if (op == 8 || op == 9) cy = f[4];
        d = {8'h00, op == 7 ? a[7:0] : r[7:0]};
        return {d, z, n, h, cy, 4'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_alu_en"}, 32'(alu_en), 32'd0);
        chk({tag, "_alu_cin"}, 32'(alu_cin), 32'd0);
        chk({tag, "_alu_ab"}, {16'h0, alu_a, alu_b}, 32'd0);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, "_res"}, {8'h0, res_data, res_flags}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every done and checks data, flags, alu_en count and timing
    always @(negedge clk) begin
        exp_t e;
        if (!rst) en_cnt = 0;
        else begin
            if (alu_en) en_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 res_data=%0h", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.d));
                    chk("res_flags", 32'(res_flags), 32'(e.f));
                    chk("alu_en_pulses", en_cnt, e.en);
                    chk("done_cycle", cyc, e.cyc);
                end
                en_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] f,
                         input bit use_k, input logic [23:0] k, input int hold);
        exp_t e;
        logic [23:0] m;
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flags_in = f;
        m = use_k ? k : ref_model(op, a, b, f);
        e.d = m[23:8]; e.f = m[7:0];
        e.en = op > 10 ? 0 : op == 10 ? 2 : 1;
        e.cyc = cyc + 1 + (4 - (int'(tb_t) + 1) % 4) % 4 + (op == 10 ? 8 : 4);
        sb.push_back(e);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            req_op = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); flags_in = 8'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_hi();
        int w = 0;
        while (!alu_en && w < 40) begin @(negedge clk); w++; end
        chk("lo_alu_en_seen", 32'(alu_en), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int w;
        rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; flags_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b1;
        issue(4'd0, 16'h003A, 16'h00C6, 8'h00, 1, {16'h0000, 8'hB0}, 0);
        issue(4'd8, 16'h00FF, 16'h1234, 8'h10, 1, {16'h0000, 8'hB0}, 0);
        issue(4'd9, 16'h0001, 16'h0000, 8'h00, 1, {16'h0000, 8'hC0}, 0);
        issue(4'd7, 16'h0010, 16'h0020, 8'h00, 1, {16'h0010, 8'h50}, 0);
        issue(4'd1, 16'h000F, 16'h0000, 8'h10, 1, {16'h0010, 8'h20}, 0);
        issue(4'd3, 16'h0000, 16'h0000, 8'h10, 1, {16'h00FF, 8'h70}, 0);
        issue(4'd4, 16'h00F0, 16'h000F, 8'h00, 1, {16'h0000, 8'hA0}, 0);
        issue(4'd15, 16'h1234, 16'h5678, 8'hB7, 1, {16'h0000, 8'hB0}, 0);
        issue(4'd10, 16'h0FFF, 16'h0001, 8'h80, 1, {16'h1000, 8'hA0}, 0);
        wait_hi();
        req_valid = 1'b1; req_op = 4'd0; req_a = 16'h1111; req_b = 16'h2222;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        issue(4'd10, 16'h8000, 16'h8000, 8'h00, 1, {16'h0000, 8'h10}, 0);
        wait_hi();
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check_reset("midop");
        rst = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom), 0, 24'h0, $urandom_range(0, 3));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        w = 0;
        while (sb.size() != 0 && w < 200) begin @(negedge clk); w++; end
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences the Game Boy ALU over M-cycles: accepts one arithmetic/logic request from the instruction decoder, drives the ALU operands, opcode, enable and carry-in, captures the ALU result and flags, and returns a merged result and flag byte.
- Derives the M-cycle framing internally from a free-running T-state counter on the single 4 MHz clock.
- Splits 16-bit ADD HL,rr into two 8-bit ALU passes.
- Applies Game Boy flag-preservation rules (INC/DEC keep C; ADD16 keeps Z).

Parameters:
- DATA_WIDTH, 8, ALU data width (from gate_boy_pkg).
- FLAG_WIDTH, 8, flag byte width: Z=bit7, N=bit6, H=bit5, C=bit4, bits 3:0 always 0.

Ports:
- clk  in  1  4 MHz system clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request strobe from decoder.
- req_ready  out  1  high when idle; a request is accepted on any clk edge where req_valid && req_ready.
- req_op  in  4  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 INC, 9 DEC, 10 ADD16; 11-15 reserved.
- req_a  in  16  operand A; bits 15:8 are used only by ADD16.
- req_b  in  16  operand B; ignored by INC and DEC.
- flags_in  in  8  current F register.
- alu_opcode  out  alu_ops_t  opcode driven to the ALU.
- alu_a, alu_b  out  8 each  ALU operands.
- alu_cin  out  1  carry/borrow-in for ADC/SBC.
- alu_en  out  1  one-clk ALU update enable.
- alu_result  in  8  ALU result.
- alu_flags  in  8  ALU flags.
- done  out  1  one-clk completion pulse.
- res_data  out  16  result; bits 15:8 are zero except for ADD16.
- res_flags  out  8  merged flags.

Behaviour:
- T-state counter
  - t_cnt is 2 bits, free-running 0→1→2→3→0.
  - Reset forces t_cnt=0.
- States: IDLE, LO, HI, FIN.
- Reset values: IDLE, req_ready=1, done=0, alu_en=0, alu_cin=0, alu_a=alu_b=0, alu_opcode=ADD, res_data=0, res_flags=0.
- Reset asserted mid-operation aborts it immediately: no done pulse, and the latched request is discarded.
- Acceptance
  - A request is accepted in IDLE only.
  - On accept, latch req_op, req_a, req_b and flags_in; req_ready drops on the next clk.
  - The FSM waits in IDLE-latched until t_cnt==0, then enters LO. An accept that occurs exactly at t_cnt==3 enters LO at the next t_cnt==0.
- LO (one full M-cycle)
  - Operands and opcode are held constant for all 4 clks.
  - alu_en pulses at t_cnt==1.
  - The sequencer captures alu_result/alu_flags at t_cnt==3.
  - Exit: HI if op==ADD16, else FIN.
- Per-operation drive in LO:
  - ADD/ADC/SUB/SBC/AND/XOR/OR: ALU opcode equal to op; alu_a=a[7:0], alu_b=b[7:0]; alu_cin = latched flags_in C for ADC/SBC, else 0.
  - CP: SUB opcode.
  - INC: ADD opcode with alu_b=1.
  - DEC: SUB opcode with alu_b=1.
  - ADD16: ADD opcode on a[7:0], b[7:0].
- HI (ADD16 only, one M-cycle)
  - ADC opcode on a[15:8], b[15:8]; alu_cin = C captured in LO.
  - Same alu_en and capture timing as LO.
- FIN (1 clk, at t_cnt==0)
  - done=1; res_data and res_flags update in this cycle and hold until the next done.
  - Next state is IDLE; req_ready=1 on the following clk.
- Result and flag merge:
  - ALU ops other than CP: res_data = {8'h00, lo result}; res_flags = captured ALU flags.
  - CP: res_data = {8'h00, a[7:0]}; res_flags = ALU SUB flags.
  - INC/DEC: Z, N, H from the ALU; C = latched flags_in C.
  - ADD16: res_data = {hi, lo}; Z = latched flags_in Z; N=0; H and C from the HI pass.
  - res_flags[3:0] is forced to 0 in every case.
- Reserved opcodes: no ALU activity (alu_en stays 0); done is still pulsed; res_data=0; res_flags = latched flags_in with bits 3:0 forced to 0.
- Latency from the start of LO to done: 8-bit ops take 4 clks; ADD16 takes 8 clks.
- req_valid while busy is ignored; the request is not queued.
- alu_en is never asserted outside LO/HI.

Test Plan:
- Reset, then hold rst low 3 clks → all outputs at reset values, req_ready=1, t_cnt=0 on release.
- ADD a=0x3A, b=0xC6 → single alu_en, done 4 clks after LO entry, res_data=0x0000, res_flags=0xB0.
- INC a=0xFF, flags_in=0x10 → ALU ADD with b=1, res_data=0x0000, res_flags=0xB0 (C preserved). DEC a=0x01, flags_in=0x00 → res_data=0x0000, res_flags=0xC0.
- CP a=0x10, b=0x20 → res_data=0x0010, res_flags=0x50.
- ADD16 a=0x0FFF, b=0x0001, flags_in=0x80 → two alu_en pulses, HI pass alu_cin=1, done after 8 clks, res_data=0x1000, res_flags=0xA0.
- ADD16 accepted; second req_valid during HI → ignored. rst low during HI → no done pulse, outputs reset. Reserved op 0xF → no alu_en, done pulse, res_data=0.
